// File: rtl/note_selector.sv
// Note selector front end: debounces four push-buttons into press pulses and
// drives a registered chromatic note frequency (C4..B4) in manual or auto-play mode.
module note_selector #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 25000000,
  parameter int GAP_CYCLES      = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_play,
  input  logic        btn_stop,
  output logic [11:0] freq,
  output logic [3:0]  note_idx,
  output logic        playing
);

  localparam int NB   = 4;
  localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {SILENT, HOLD, AUTO_NOTE, AUTO_GAP} state_t;

  function automatic logic [11:0] note_freq(input logic [3:0] idx);
    case (idx)
      4'd0:    note_freq = 12'd261;
      4'd1:    note_freq = 12'd277;
      4'd2:    note_freq = 12'd293;
      4'd3:    note_freq = 12'd311;
      4'd4:    note_freq = 12'd330;
      4'd5:    note_freq = 12'd349;
      4'd6:    note_freq = 12'd370;
      4'd7:    note_freq = 12'd392;
      4'd8:    note_freq = 12'd415;
      4'd9:    note_freq = 12'd440;
      4'd10:   note_freq = 12'd466;
      4'd11:   note_freq = 12'd494;
      default: note_freq = 12'd0;
    endcase
  endfunction

  // Bit order: 0 up, 1 down, 2 play, 3 stop.
  logic [NB-1:0] raw, sync1, sync2, level, level_q, press;
  logic [DW-1:0] db_cnt [NB];

  assign raw = {btn_stop, btn_play, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      press   <= '0;
      // NOTE: the counter array is reset element by element because a stuck
      // count after reset would shorten the first debounce window.
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the synchroniser a true two-stage
      // shift register regardless of statement order.
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic up, down, play, stop, step;
  assign up   = press[0];
  assign down = press[1];
  assign play = press[2];
  assign stop = press[3];
  assign step = up ^ down;  // coincident up/down cancel

  state_t        state, state_n;
  logic [3:0]    idx_n, idx_inc, idx_dec, idx_step;
  logic [TW-1:0] timer, timer_n;

  assign idx_inc  = (note_idx == 4'd11) ? 4'd0 : note_idx + 4'd1;
  assign idx_dec  = (note_idx == 4'd0) ? 4'd11 : note_idx - 4'd1;
  assign idx_step = up ? idx_inc : idx_dec;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_n = state;
    idx_n   = note_idx;
    timer_n = timer;
    unique case (state)
      SILENT: begin
        if (stop) begin
          state_n = SILENT;
        end else if (play) begin
          state_n = AUTO_NOTE;
          timer_n = '0;
        end else if (step) begin
          idx_n   = idx_step;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          state_n = SILENT;
        end else if (play) begin
          state_n = AUTO_NOTE;
          timer_n = '0;
        end else if (step) begin
          idx_n = idx_step;
        end
      end
      AUTO_NOTE: begin
        timer_n = '0;
        if (stop)                    state_n = SILENT;
        else if (play)               state_n = HOLD;
        else if (timer == STEP_LAST) state_n = AUTO_GAP;
        else                         timer_n = timer + 1'b1;
      end
      AUTO_GAP: begin
        timer_n = '0;
        if (stop) begin
          state_n = SILENT;
        end else if (play) begin
          state_n = HOLD;
        end else if (timer == GAP_LAST) begin
          idx_n   = idx_inc;
          state_n = AUTO_NOTE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
    endcase
  end

  // Outputs are computed from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SILENT;
      timer    <= '0;
      note_idx <= '0;
      freq     <= '0;
      playing  <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      note_idx <= idx_n;
      freq     <= (state_n == HOLD || state_n == AUTO_NOTE) ? note_freq(idx_n) : 12'd0;
      playing  <= (state_n == AUTO_NOTE || state_n == AUTO_GAP);
    end
  end

endmodule

// File: tb/tb_note_selector.sv
// Scoreboard bench for note_selector: stimulus queues expected output changes
// with their exact cycle; a negedge monitor pops and compares on every change.
module tb_note_selector;

  localparam int DB   = 4;
  localparam int STEP = 10;
  localparam int GAP  = 2;
  localparam int LAT  = 2 + DB + 1 + 1;  // launch cycle to output edge

  localparam logic [3:0] UP   = 4'b0001;
  localparam logic [3:0] DOWN = 4'b0010;
  localparam logic [3:0] PLAY = 4'b0100;
  localparam logic [3:0] STOP = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic [11:0] freq;
  logic [3:0]  note_idx;
  logic        playing;

  always #5 clk = ~clk;

  note_selector #(
    .DEBOUNCE_CYCLES(DB),
    .STEP_CYCLES    (STEP),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_up  (btn[0]),
    .btn_down(btn[1]),
    .btn_play(btn[2]),
    .btn_stop(btn[3]),
    .freq    (freq),
    .note_idx(note_idx),
    .playing (playing)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [16:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [16:0] prev = '0;
  logic [16:0] cur;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input int c, input logic [16:0] v);
    return $sformatf("cyc=%0d freq=%0d idx=%0d playing=%0b", c, v[16:5], v[4:1], v[0]);
  endfunction

  task automatic check(input string name, input bit ok, input string got, input string want);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  task automatic push_exp(input string name, input int c, input int f, input int i, input bit p);
    sb.push_back('{name: name, cyc: c, val: {12'(f), 4'(i), p}});
  endtask

  task automatic launch(input logic [3:0] m, output int t0);
    btn = btn | m;
    t0  = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic release_btns();
    btn = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic press(input string name, input logic [3:0] m, input int f, input int i, input bit p);
    int t0;
    launch(m, t0);
    push_exp(name, t0 + LAT, f, i, p);
    repeat (8) @(negedge clk);
    release_btns();
  endtask

  task automatic press_quiet(input logic [3:0] m);
    int t0;
    launch(m, t0);
    repeat (8) @(negedge clk);
    release_btns();
  endtask

  // Any output change, or the arrival of an expected cycle, consumes one entry.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {freq, note_idx, playing};
      if (cur != prev || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
        if (sb.size() == 0) begin
          check("unexpected_change", cur == prev, fmt(cyc, cur), fmt(cyc, prev));
        end else begin
          e = sb.pop_front();
          check(e.name, cyc == e.cyc && cur == e.val, fmt(cyc, cur), fmt(e.cyc, e.val));
        end
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, p;
    rst = 1'b1;
    btn = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {freq, note_idx, playing} == 17'd0,
          fmt(cyc, {freq, note_idx, playing}), fmt(cyc, 17'd0));
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_silent", {freq, note_idx, playing} == 17'd0,
          fmt(cyc, {freq, note_idx, playing}), fmt(cyc, 17'd0));

    // Long hold gives one step; first sampling edge + 7 is the output edge.
    launch(UP, t0);
    push_exp("up_latency", t0 + LAT, 277, 1, 0);
    repeat (20) @(negedge clk);
    release_btns();

    // Two-cycle glitch is shorter than the debounce window.
    btn = DOWN;
    repeat (2) @(negedge clk);
    release_btns();

    press("down_to_0",  DOWN, 261, 0,  0);
    press("down_wrap",  DOWN, 494, 11, 0);
    press("up_wrap",    UP,   261, 0,  0);
    press("down_to_11", DOWN, 494, 11, 0);
    press("down_to_10", DOWN, 466, 10, 0);

    // Auto run from note 10: 10 cycles sounding, 2 cycles silent, wraps to 0.
    launch(PLAY, t0);
    p = t0 + LAT;
    push_exp("auto_start", p,      466, 10, 1);
    push_exp("auto_gap1",  p + 10, 0,   10, 1);
    push_exp("auto_n11",   p + 12, 494, 11, 1);
    push_exp("auto_gap2",  p + 22, 0,   11, 1);
    push_exp("auto_wrap",  p + 24, 261, 0,  1);
    push_exp("auto_gap3",  p + 34, 0,   0,  1);
    repeat (8) @(negedge clk);
    btn = '0;
    // Pause pulse lands on the gap terminal count; pause must win, no advance.
    wait_until(p + 36 - LAT);
    launch(PLAY, t0);
    push_exp("pause_in_gap", t0 + LAT, 261, 0, 0);
    repeat (8) @(negedge clk);
    release_btns();

    press("hold_up",        UP,   277, 1, 0);
    press("stop_keeps_idx", STOP, 0,   1, 0);
    press("silent_up",      UP,   293, 2, 0);
    press_quiet(UP | DOWN);
    press("play_stop",      PLAY | STOP, 0, 2, 0);

    // Reset in the middle of a sounding auto note.
    launch(PLAY, t0);
    p = t0 + LAT;
    push_exp("auto_from_silent", p, 293, 2, 1);
    repeat (8) @(negedge clk);
    btn = '0;
    wait_until(p + 4);
    rst = 1'b1;
    push_exp("reset_mid_auto", p + 5, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    mon_en = 1'b0;
    check("scoreboard_drained", sb.size() == 0,
          $sformatf("%0d pending", sb.size()), "0 pending");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
